video_timing_ctrl: RTL and testbench

- Frame sequencer that drives the pixel pipeline (region_bin and sibling filters).
- Generates vsync/hsync/valid timing from programmable counters.
- Pulls 8-bit pixels from an upstream source through a valid/ready handshake and presents them as a pre_img_* stream.
- Supports continuous and single-shot frame modes, graceful stop at frame end, and underflow reporting.

---
 rtl/video_timing_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: frame sequencer for the pixel pipeline.
// Runs programmable h/v counters, decodes sync and active timing, pulls one
// pixel per active slot from an upstream valid/ready source and presents it
// one cycle later as the pre_img_* stream with matching out_x/out_y.
// Optional build macro TEST_PATTERN_EN adds a pattern_on input. When it is
// set at frame start, that frame shows a diagonal (x+y) test pattern and
// ignores the upstream source.
module video_timing_ctrl #(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 110,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_FRONT = 5,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef TEST_PATTERN_EN
  input  logic             pattern_on,
`endif
  input  logic             enable,
  input  logic             single_shot,
  input  logic [7:0]       src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             pre_img_vsync,
  output logic             pre_img_hsync,
  output logic             pre_img_valid,
  output logic [7:0]       pre_img_data,
  output logic [CNT_W-1:0] out_x,
  output logic [CNT_W-1:0] out_y,
  output logic             busy,
  output logic             frame_done,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [CNT_W-1:0] H_SYN_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_SYNC + V_BACK + V_DISP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;

  logic             run_p0;
  logic             eol_p0;
  logic             eof_p0;
  logic             vs_p0;
  logic             hs_p0;
  logic             act_p0;
  logic [CNT_W-1:0] x_p0;
  logic [CNT_W-1:0] y_p0;
  logic [7:0]       pix_p0;
  logic             pat_sel;

  logic             vs_p1;
  logic             hs_p1;
  logic             vld_p1;
  logic [7:0]       data_p1;
  logic [CNT_W-1:0] x_p1;
  logic [CNT_W-1:0] y_p1;
  logic             fd_p1;
  logic             uf_p1;

`ifdef TEST_PATTERN_EN
  logic pat_frame;

  // Diagonal test pattern value; wraps modulo 256.
  function automatic logic [7:0] pat_pixel(input logic [CNT_W-1:0] x,
                                           input logic [CNT_W-1:0] y);
    logic [CNT_W-1:0] s;
    s = x + y;
    return s[7:0];
  endfunction

  // Latch pattern_on only while the counters sit at frame origin so a frame is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_frame <= 1'b0;
    end else if (h_cnt_p0 == '0 && v_cnt_p0 == '0) begin
      pat_frame <= pattern_on;
    end
  end

  assign pat_sel = pat_frame;
`else
  assign pat_sel = 1'b0;
`endif

  // ---- stage p0: counters and combinational timing decode ----
  assign run_p0 = (state != S_IDLE);
  assign eol_p0 = (h_cnt_p0 == H_LAST);
  assign eof_p0 = eol_p0 && (v_cnt_p0 == V_LAST);
  assign vs_p0  = run_p0 && (v_cnt_p0 < V_SYN_E);
  assign hs_p0  = run_p0 && (h_cnt_p0 < H_SYN_E);
  assign act_p0 = run_p0 &&
                  (h_cnt_p0 >= H_ACT_S) && (h_cnt_p0 < H_ACT_E) &&
                  (v_cnt_p0 >= V_ACT_S) && (v_cnt_p0 < V_ACT_E);
  assign x_p0   = h_cnt_p0 - H_ACT_S;
  assign y_p0   = v_cnt_p0 - V_ACT_S;

  // Upstream is only asked for a pixel in an active slot of a source-fed frame.
  assign src_ready = act_p0 && !pat_sel;
  assign busy      = run_p0;

  // Pixel for the current slot: pattern, upstream data, or 0 on underflow / blanking.
  always_comb begin
    pix_p0 = 8'h00;
    if (act_p0) begin
`ifdef TEST_PATTERN_EN
      if (pat_sel) begin
        pix_p0 = pat_pixel(x_p0, y_p0);
      end else if (src_valid) begin
        pix_p0 = src_data;
      end
`else
      if (src_valid) begin
        pix_p0 = src_data;
      end
`endif
    end
  end

  // Frame sequencer: run/stop/idle control, single-shot arming and the h/v counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      armed    <= 1'b1;
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          h_cnt_p0 <= '0;
          v_cnt_p0 <= '0;
          if (!enable) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_RUN;
          end
        end
        S_RUN, S_STOP: begin
          if (eol_p0) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= eof_p0 ? '0 : v_cnt_p0 + ONE;
          end else begin
            h_cnt_p0 <= h_cnt_p0 + ONE;
          end
          if (eof_p0) begin
            // Back-to-back frames only from RUN with a continuous request.
            if (state == S_RUN && enable && !single_shot) begin
              state <= S_RUN;
            end else begin
              state <= S_IDLE;
            end
            if (single_shot) begin
              armed <= 1'b0;
            end
          end else begin
            // A frame in flight always completes; enable only picks RUN vs STOP.
            state <= enable ? S_RUN : S_STOP;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- stage p1: registered outputs, one cycle behind the counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_p1   <= 1'b0;
      hs_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      data_p1 <= 8'h00;
      x_p1    <= '0;
      y_p1    <= '0;
      fd_p1   <= 1'b0;
      uf_p1   <= 1'b0;
    end else begin
      vs_p1   <= vs_p0;
      hs_p1   <= hs_p0;
      vld_p1  <= act_p0;
      data_p1 <= pix_p0;
      x_p1    <= act_p0 ? x_p0 : '0;
      y_p1    <= act_p0 ? y_p0 : '0;
      fd_p1   <= run_p0 && eof_p0;
      uf_p1   <= act_p0 && !src_valid && !pat_sel;
    end
  end

  assign pre_img_vsync = vs_p1;
  assign pre_img_hsync = hs_p1;
  assign pre_img_valid = vld_p1;
  assign pre_img_data  = data_p1;
  assign out_x         = x_p1;
  assign out_y         = y_p1;
  assign frame_done    = fd_p1;
  assign underflow     = uf_p1;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl with a 20x20 total raster (15x15 active).
// A frame-position model predicts every output each cycle; directed
// scenarios add literal checks on key timing points.
module tb_video_timing_ctrl;

  localparam int HT = 20;
  localparam int VT = 20;
  localparam int HA = 3;    // first active column (sync + back porch)
  localparam int VA = 3;    // first active line
  localparam int HD = 15;
  localparam int VD = 15;
  localparam int FRAME = HT * VT;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n, enable, single_shot, src_valid, pattern_on;
  logic [7:0]    src_data;
  logic          src_ready, pre_img_vsync, pre_img_hsync, pre_img_valid;
  logic [7:0]    pre_img_data;
  logic [CW-1:0] out_x, out_y;
  logic          busy, frame_done, underflow;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .H_SYNC(1), .H_BACK(2), .H_DISP(15), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(15), .V_FRONT(2),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef TEST_PATTERN_EN
    .pattern_on(pattern_on),
`endif
    .enable(enable),
    .single_shot(single_shot),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .pre_img_vsync(pre_img_vsync),
    .pre_img_hsync(pre_img_hsync),
    .pre_img_valid(pre_img_valid),
    .pre_img_data(pre_img_data),
    .out_x(out_x),
    .out_y(out_y),
    .busy(busy),
    .frame_done(frame_done),
    .underflow(underflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame position based) ----------------
  bit         m_run, m_armed, m_en_last, m_pat;
  int         m_pos;
  bit         e_vs, e_hs, e_vld, e_uf, e_fd;
  logic [7:0] e_data;
  int         e_x, e_y;
  int         mx, my;
  bit         ma;

  function automatic bit in_act(input int pos);
    int x, y;
    x = pos % HT;
    y = pos / HT;
    return (x >= HA) && (x < HA + HD) && (y >= VA) && (y < VA + VD);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_armed = 1; m_en_last = 0; m_pat = 0; m_pos = 0;
      e_vs = 0; e_hs = 0; e_vld = 0; e_uf = 0; e_fd = 0; e_data = 8'h00; e_x = 0; e_y = 0;
    end else begin
      if (m_run) begin
        mx = m_pos % HT;
        my = m_pos / HT;
        ma = in_act(m_pos);
        e_vs  = (my < 1);
        e_hs  = (mx < 1);
        e_vld = ma;
        e_x   = ma ? mx - HA : 0;
        e_y   = ma ? my - VA : 0;
        if (!ma)              e_data = 8'h00;
        else if (m_pat)       e_data = 8'((mx - HA) + (my - VA));
        else if (src_valid)   e_data = src_data;
        else                  e_data = 8'h00;
        e_uf  = ma && !src_valid && !m_pat;
        e_fd  = (m_pos == FRAME - 1);
      end else begin
        e_vs = 0; e_hs = 0; e_vld = 0; e_uf = 0; e_fd = 0; e_data = 8'h00; e_x = 0; e_y = 0;
      end
      if (!m_run || m_pos == 0) m_pat = pattern_on;
      if (m_run) begin
        if (m_pos == FRAME - 1) begin
          if (!(m_en_last && enable && !single_shot)) m_run = 0;
          if (single_shot) m_armed = 0;
          m_pos = 0;
        end else begin
          m_pos++;
        end
        m_en_last = enable;
      end else if (!enable) begin
        m_armed = 1;
      end else if (m_armed) begin
        m_run = 1; m_pos = 0; m_en_last = 1;
      end
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int n_vld = 0, n_xfer = 0, n_fd = 0, n_uf = 0, cyc = 0, last_fd = -1, period = 0;

  always @(negedge clk) begin
    chk("vsync",  32'(pre_img_vsync), 32'(e_vs));
    chk("hsync",  32'(pre_img_hsync), 32'(e_hs));
    chk("valid",  32'(pre_img_valid), 32'(e_vld));
    chk("data",   32'(pre_img_data),  32'(e_data));
    chk("out_x",  32'(out_x),         32'(e_x));
    chk("out_y",  32'(out_y),         32'(e_y));
    chk("fdone",  32'(frame_done),    32'(e_fd));
    chk("uflow",  32'(underflow),     32'(e_uf));
    chk("busy",   32'(busy),          32'(m_run));
    chk("ready",  32'(src_ready),     32'(m_run && in_act(m_pos) && !m_pat));
    if (pre_img_valid) n_vld++;
    if (src_ready && src_valid) n_xfer++;
    if (underflow) n_uf++;
    if (frame_done) begin
      n_fd++;
      if (last_fd >= 0) period = cyc - last_fd;
      last_fd = cyc;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  bit         drop_en = 0;
  int         drop_pos = 10 * HT + 7;  // pixel x=4, y=7
  int         cap_pos  = 10 * HT + 8;  // its right-hand neighbour
  logic [7:0] cap_data;
  int         s_vld, s_xfer, s_fd, s_uf;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      src_data  = src_data + 8'd1;
      src_valid = !(drop_en && m_run && m_pos == drop_pos);
      if (m_run && m_pos == cap_pos) cap_data = src_data;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (busy && k < max_cyc) begin
      step(1);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vs"},   32'(pre_img_vsync), 0);
    chk({tag, "_hs"},   32'(pre_img_hsync), 0);
    chk({tag, "_vld"},  32'(pre_img_valid), 0);
    chk({tag, "_data"}, 32'(pre_img_data),  0);
    chk({tag, "_x"},    32'(out_x),         0);
    chk({tag, "_y"},    32'(out_y),         0);
    chk({tag, "_busy"}, 32'(busy),          0);
    chk({tag, "_fd"},   32'(frame_done),    0);
    chk({tag, "_uf"},   32'(underflow),     0);
    chk({tag, "_rdy"},  32'(src_ready),     0);
  endtask

  initial begin
    rst_n = 0; enable = 0; single_shot = 0; src_valid = 1; src_data = 8'h00; pattern_on = 0;
    step(3);
    chk_all_zero("reset");
    rst_n = 1;
    step(2);

    // Continuous mode: timing of first frame and two-frame statistics.
    enable = 1;
    step(1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_vs_e0", 32'(pre_img_vsync), 0);
    step(1);
    chk("t1_vs_e1", 32'(pre_img_vsync), 1);
    chk("t1_hs_e1", 32'(pre_img_hsync), 1);
    s_vld = n_vld; s_xfer = n_xfer; s_fd = n_fd;
    step(FRAME * 2);
    chk("t1_fd_cnt",  32'(n_fd - s_fd), 2);
    chk("t1_period",  32'(period), FRAME);
    chk("t1_vld_cnt", 32'(n_vld - s_vld), 2 * HD * VD);
    chk("t1_xfer",    32'(n_xfer - s_xfer), 2 * HD * VD);
    enable = 0;
    wait_idle(500);

    // Single-shot: one frame per enable assertion.
    single_shot = 1; enable = 1;
    step(1);
    chk("t2_busy", 32'(busy), 1);
    s_fd = n_fd;
    step(FRAME);
    chk("t2_fd",   32'(frame_done), 1);
    chk("t2_idle", 32'(busy), 0);
    step(FRAME);
    chk("t2_one_frame", 32'(n_fd - s_fd), 1);
    chk("t2_still_idle", 32'(busy), 0);
    enable = 0;
    step(1);
    enable = 1;
    step(1);
    chk("t2_rearm", 32'(busy), 1);
    step(FRAME);
    chk("t2_fd2",  32'(frame_done), 1);
    chk("t2_idle2", 32'(busy), 0);
    step(50);
    chk("t2_two_frames", 32'(n_fd - s_fd), 2);
    single_shot = 0; enable = 0;
    step(2);

    // Enable dropped at line 5: the frame still completes in full.
    enable = 1;
    step(1);
    s_vld = n_vld; s_fd = n_fd;
    step(5 * HT + 3);
    enable = 0;
    wait_idle(500);
    step(50);
    chk("t3_vld_cnt", 32'(n_vld - s_vld), HD * VD);
    chk("t3_fd_cnt",  32'(n_fd - s_fd), 1);

    // Enable dips mid-frame and returns: running continues into the next frame.
    enable = 1;
    step(1);
    s_fd = n_fd;
    step(60);
    enable = 0;
    step(5);
    enable = 1;
    step(FRAME);
    chk("t3b_cont_busy", 32'(busy), 1);
    chk("t3b_fd_cnt",    32'(n_fd - s_fd), 1);
    enable = 0;
    wait_idle(500);

    // Underflow at pixel (4,7).
    drop_en = 1;
    enable = 1;
    step(1);
    s_uf = n_uf;
    step(drop_pos + 1);
    chk("t4_vld",  32'(pre_img_valid), 1);
    chk("t4_data", 32'(pre_img_data), 0);
    chk("t4_uf",   32'(underflow), 1);
    chk("t4_x",    32'(out_x), 4);
    chk("t4_y",    32'(out_y), 7);
    step(1);
    chk("t4_nb_data", 32'(pre_img_data), 32'(cap_data));
    chk("t4_nb_uf",   32'(underflow), 0);
    chk("t4_nb_x",    32'(out_x), 5);
    enable = 0;
    wait_idle(500);
    step(20);
    chk("t4_uf_cnt", 32'(n_uf - s_uf), 1);
    drop_en = 0;

    // Async reset mid-line 9, then a fresh frame.
    enable = 1;
    step(1);
    step(9 * HT + 8);
    #1;
    rst_n = 0;
    #1;
    chk_all_zero("arst");
    step(1);
    rst_n = 1;
    step(1);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_vs0",  32'(pre_img_vsync), 0);
    step(1);
    chk("t5_vs1",  32'(pre_img_vsync), 1);
    chk("t5_hs1",  32'(pre_img_hsync), 1);
    step(FRAME - 1);
    chk("t5_fd",   32'(frame_done), 1);
    enable = 0;
    wait_idle(500);

`ifdef TEST_PATTERN_EN
    // Pattern frame, with pattern_on dropped mid-frame taking effect only next frame.
    pattern_on = 1; enable = 1;
    step(1);
    s_xfer = n_xfer;
    step(100);
    pattern_on = 0;
    step((VA + 14) * HT + HA + 14 + 1 - 100);
    chk("t6_pix14", 32'(pre_img_data), 32'h1C);
    chk("t6_x14",   32'(out_x), 14);
    chk("t6_xfer",  32'(n_xfer - s_xfer), 0);
    step(FRAME);
    chk("t6_off_xfer", 32'(n_xfer - s_xfer > 0), 1);
    enable = 0;
    wait_idle(500);
`endif

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
